// File: rtl/spi_mnrch.sv
// spi_mnrch: 16-bit SPI master used by inert_intf to talk to the inertial
// sensor. One wrt pulse launches one full-duplex transaction. SCLK idles high;
// MOSI changes on SCLK falling edges and MISO is sampled on rising edges.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   wrt      one-clk start pulse, accepted only while idle
//   wt_data  word to transmit (MSB first), captured on the accepted wrt cycle
//   MISO     serial data from the sensor
//   done     set when a transaction completes, cleared by the next accepted wrt
//   rd_data  received word (the shift register), valid while done=1
//   SS_n     active-low slave select
//   SCLK     serial clock (divider MSB)
//   MOSI     serial data to the sensor (shift register MSB)
module spi_mnrch #(
    parameter int unsigned SCLK_DIV_W = 5,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt,
    input  logic [DATA_W-1:0] wt_data,
    input  logic              MISO,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    localparam logic [SCLK_DIV_W-1:0] DIV_ONES   = '1;
    // Divider value one clk before SCLK rises: MISO is sampled here.
    localparam logic [SCLK_DIV_W-1:0] DIV_SAMPLE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    // Start value: SCLK stays high for a quarter period before the first fall.
    localparam logic [SCLK_DIV_W-1:0] DIV_START  = {2'b10, {(SCLK_DIV_W-2){1'b1}}};
    localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        PORCH,
        SHIFT,
        BACK
    } state_e;

    state_e                state_q, state_d;
    logic [SCLK_DIV_W-1:0] div_q,   div_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  miso_q,  miso_d;
    logic                  ss_n_q,  ss_n_d;
    logic                  done_q,  done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '1;
            cnt_q   <= '0;
            shift_q <= '0;
            miso_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            miso_q  <= miso_d;
            ss_n_q  <= ss_n_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        miso_d  = miso_q;
        ss_n_d  = ss_n_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                div_d = DIV_ONES;
                if (wrt) begin
                    state_d = PORCH;
                    shift_d = wt_data;
                    ss_n_d  = 1'b0;
                    done_d  = 1'b0;
                    div_d   = DIV_START;
                    cnt_d   = '0;
                end
            end
            PORCH: begin
                // First SCLK fall carries no shift; MOSI already shows the MSB.
                div_d = div_q + 1'b1;
                if (div_q == DIV_ONES) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                div_d = div_q + 1'b1;
                if (div_q == DIV_SAMPLE) begin
                    miso_d = MISO;
                end
                if (div_q == DIV_ONES) begin
                    shift_d = {shift_q[DATA_W-2:0], miso_q};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Freeze SCLK high (no trailing fall) and release SS_n
                        // together with done on the following clk.
                        div_d   = div_q;
                        state_d = BACK;
                        ss_n_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            BACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SCLK    = div_q[SCLK_DIV_W-1];
    assign MOSI    = shift_q[DATA_W-1];
    assign rd_data = shift_q;
    assign SS_n    = ss_n_q;
    assign done    = done_q;

endmodule

// File: tb/tb_spi_mnrch.sv
// Testbench for spi_mnrch: randomized loopback and sensor-model transactions
// with a scoreboard for received words and transmitted bitstreams, plus SPI
// framing/timing checks done by a monitor on the falling clk edge.
module tb_spi_mnrch;

    logic        clk;
    logic        rst_n;
    logic        wrt;
    logic [15:0] wt_data;
    logic        MISO;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;

    // Sensor model / loopback selection.
    logic        loop_mode;
    logic [15:0] sens_resp;
    logic        sens_bit;

    int          ncmp;
    int          nfail;

    logic [15:0] exp_rd[$];
    logic [15:0] exp_tx[$];

    spi_mnrch #(
        .SCLK_DIV_W(5),
        .DATA_W    (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wrt    (wrt),
        .wt_data(wt_data),
        .MISO   (MISO),
        .done   (done),
        .rd_data(rd_data),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI)
    );

    assign MISO = loop_mode ? MOSI : sens_bit;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc;
    int          ss_start;
    int          rises;
    int          falls;
    int          last_rise;
    bit          active;
    logic [15:0] tx_cap;
    logic        ss_prev;
    logic        sclk_prev;
    logic        mosi_prev;
    logic        done_prev;
    logic [15:0] rd_prev;

    initial begin
        cyc = 0; active = 0; ss_prev = 1'b1; sclk_prev = 1'b1;
        mosi_prev = 1'b0; done_prev = 1'b0; rd_prev = '0; sens_bit = 1'b0;
    end

    always @(negedge clk) begin
        logic [15:0] e;
        cyc++;
        if (!rst_n) begin
            active = 0;
        end else begin
            if (ss_prev && !SS_n) begin
                active    = 1;
                ss_start  = cyc;
                rises     = 0;
                falls     = 0;
                last_rise = 0;
                tx_cap    = '0;
                sens_bit  = sens_resp[15];
                chk("sclk_high_at_ss_fall", SCLK, 1);
            end
            if (active && !sclk_prev && SCLK) begin
                rises++;
                chk("mosi_stable_at_rise", MOSI, mosi_prev);
                // Edge launched at the end of cycle t0+24 is seen in cycle t0+25.
                if (rises == 1) chk("first_rise_offset", cyc - ss_start, 25);
                else            chk("sclk_period", cyc - last_rise, 32);
                last_rise = cyc;
                tx_cap    = {tx_cap[14:0], MOSI};
            end
            if (active && sclk_prev && !SCLK) begin
                falls++;
                if (falls <= 16) sens_bit = sens_resp[16 - falls];
            end
            if (active && !ss_prev && SS_n) begin
                active = 0;
                chk("ss_low_window", cyc - ss_start, 521);
                chk("sclk_high_at_ss_rise", SCLK, 1);
                chk("sclk_rises", rises, 16);
                chk("sclk_falls", falls, 16);
                chk("done_with_ss_rise", done, 1);
                if (exp_tx.size() == 0) begin
                    chk("tx_unexpected", 1, 0);
                end else begin
                    e = exp_tx.pop_front();
                    chk("mosi_stream", tx_cap, e);
                end
            end
            if (!done_prev && done) begin
                if (exp_rd.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = exp_rd.pop_front();
                    chk("rd_data", rd_data, e);
                end
            end
            if (done_prev && done) chk("rd_data_stable", rd_data, rd_prev);
        end
        ss_prev   = SS_n;
        sclk_prev = SCLK;
        mosi_prev = MOSI;
        done_prev = done;
        rd_prev   = rd_data;
    end

    // ---------------- stimulus ----------------
    // Issues a wrt expected to be accepted; returns in cycle t0.
    task automatic issue(input logic [15:0] data, input bit loop, input logic [15:0] resp);
        @(posedge clk); #1;
        loop_mode = loop;
        sens_resp = resp;
        wt_data   = data;
        wrt       = 1'b1;
        exp_rd.push_back(loop ? data : resp);
        exp_tx.push_back(data);
        @(posedge clk); #1;
        wrt     = 1'b0;
        wt_data = 16'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_timeout", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ncmp = 0; nfail = 0;
        rst_n = 1'b0; wrt = 1'b0; wt_data = '0; loop_mode = 1'b1; sens_resp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ss_n", SS_n, 1);
        chk("rst_sclk", SCLK, 1);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mosi", MOSI, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed loopback.
        issue(16'hA5C3, 1, 16'h0000);
        wait_done();

        // Sensor read.
        issue(16'h8F00, 0, 16'h006A);
        wait_done();
        chk("sensor_low_byte", rd_data[7:0], 8'h6A);

        // wrt mid-transaction is ignored.
        issue(16'h1234, 1, 16'h0000);
        repeat (100) @(posedge clk);
        #1;
        wt_data = 16'hFFFF; wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0;
        wait_done();

        // wrt in the cycle done rises is ignored.
        issue(16'h5A5A, 1, 16'h0000);
        repeat (521) @(posedge clk);
        #1;
        chk("done_at_t0_521", done, 1);
        wt_data = 16'hFFFF; wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0;
        @(negedge clk);
        chk("wrt_at_done_ignored_ss", SS_n, 1);
        chk("wrt_at_done_ignored_done", done, 1);

        // Back-to-back: second wrt the clk after done.
        issue(16'h0001, 1, 16'h0000);
        wait_done();
        issue(16'h8000, 1, 16'h0000);
        @(negedge clk);
        chk("done_drops_after_wrt", done, 0);
        wait_done();

        // Randomized loopback and sensor transactions.
        for (int i = 0; i < 8; i++) begin
            issue(16'($urandom), 1, 16'h0000);
            wait_done();
        end
        for (int i = 0; i < 4; i++) begin
            issue(16'($urandom), 0, 16'($urandom));
            wait_done();
        end

        // Reset mid-transaction at t0+300.
        issue(16'($urandom), 1, 16'h0000);
        repeat (300) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ss_n", SS_n, 1);
        chk("midrst_sclk", SCLK, 1);
        chk("midrst_done", done, 0);
        chk("midrst_rd_data", rd_data, 0);
        exp_rd.delete();
        exp_tx.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        issue(16'($urandom), 1, 16'h0000);
        wait_done();

        repeat (5) @(posedge clk);
        chk("sb_rd_empty", exp_rd.size(), 0);
        chk("sb_tx_empty", exp_tx.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/spi_mnrch.md
Name: spi_mnrch

Overview:
- 16-bit SPI master ("monarch") that inert_intf uses to talk to the inertial sensor. It drives SS_n, SCLK and MOSI, and samples MISO.
- Sits directly between inert_intf's command/readout state machine and the external sensor pins.
- One write launches one full-duplex 16-bit transaction. Completion is flagged with done; received data is presented on rd_data.

Parameters:
- SCLK_DIV_W, 5: width of the SCLK divider counter. SCLK period = 2^SCLK_DIV_W clk cycles (32 by default).
- DATA_W, 16: transaction length in bits; also the width of wt_data and rd_data.

Ports:
- clk       input   1        system clock
- rst_n     input   1        reset, asynchronous, active-low
- wrt       input   1        one-clk pulse; starts a transaction when idle
- wt_data   input   DATA_W   word to transmit, MSB first; captured on the wrt cycle
- MISO      input   1        serial data from the sensor
- done      output  1        high once a transaction completes; held until the next accepted wrt
- rd_data   output  DATA_W   received word; valid while done=1
- SS_n      output  1        active-low slave select
- SCLK      output  1        serial clock; idles high
- MOSI      output  1        serial data to the sensor; equals shift_reg[DATA_W-1]

Behaviour:
- Reset values: SS_n=1, SCLK=1, done=0, shift_reg=0 (so rd_data=0 and MOSI=0), state=IDLE, divider=all ones, bit count=0.
- Internals:
  - Single DATA_W shift register; transmit and receive share it.
  - SCLK = divider MSB.
  - 1-bit MISO sample flop.
  - Bit counter counting 0..DATA_W.
- States:
  - IDLE: SS_n=1; divider held at all ones, so SCLK=1.
  - PORCH: first SCLK fall; no shift.
  - SHIFT: bit transfers.
  - BACK: completion.
- IDLE -> PORCH on wrt. In the next clk:
  - shift_reg <= wt_data, SS_n <= 0, done <= 0;
  - divider <= 10111 (default width), bit count <= 0.
  - Call the cycle where SS_n is first low t0.
- Divider increments every clk while not IDLE.
- Divider 11111 -> 00000 is the SCLK falling edge; divider 01111 -> 10000 is the rising edge.
- PORCH: the first 11111 at t0+8 drives the SCLK fall without shifting, then goes to SHIFT. MOSI already holds wt_data[15].
- Sample event: in SHIFT, divider == 01111 (clk before SCLK rises) -> MISO sample flop <= MISO.
- Shift event: in SHIFT, divider == 11111 -> shift_reg <= {shift_reg[DATA_W-2:0], sample}; bit count++.
- On the shift event that makes bit count == DATA_W (t0+520 by default):
  - divider frozen at 11111, so SCLK stays high (no 17th fall); state -> BACK.
  - Next clk (t0+521): SS_n=1, done=1, state -> IDLE.
- Totals per transaction: SS_n low for exactly 521 clks; exactly 16 SCLK rising edges, at t0+24+32k for k=0..15.
- rd_data = shift_reg continuously; it is stable and equal to the received word from done=1 until the next accepted wrt.
- wrt while not IDLE is ignored: no restart, shift_reg unaffected.
- wrt in the same clk that done rises (BACK -> IDLE) is ignored. A wrt on any later IDLE clk is accepted.
- Back-to-back transactions: SS_n is high for at least 1 clk between transactions.
- Reset mid-transaction: all state and outputs return to reset values immediately (async). No partial done.
- MISO is sampled only by the sample flop; it is not synchronized here, because the sensor is clocked by SCLK.

Test Plan:
- Loopback: tie MOSI->MISO; wrt with wt_data=16'hA5C3 -> rd_data=16'hA5C3; done rises exactly 521 clks after SS_n falls; SS_n rises in the same cycle as done.
- SCLK checker: during one transaction, count 16 rising and 16 falling SCLK edges; period 32 clks; SCLK high when SS_n falls and when SS_n rises; MOSI stable across every rising edge.
- Sensor model returning 16'h006A for a read of 16'h8F00 -> rd_data[7:0]=8'h6A; MOSI bitstream captured by the model equals 16'h8F00.
- wrt pulsed at t0+100 with wt_data=16'hFFFF during an active 16'h1234 loopback transaction -> ignored; rd_data=16'h1234; still one 521-clk SS_n window.
- rst_n asserted at t0+300 -> same clk: SS_n=1, SCLK=1, done=0, rd_data=0. A new wrt after release completes a normal transaction.
- Back-to-back: wrt issued the clk after done, 16'h0001 then 16'h8000 -> both round-trip in loopback; done drops the clk after the second wrt.
